// File: rtl/packet_filter_if.sv
// Avalon-ST stream bundle shared by the packet_filter sink and source ports.
// Carries data, framing, empty byte count and channel with valid/ready flow control.
interface avalon_st_if #(
  parameter int AST_DWIDTH    = 64,
  parameter int CHANNEL_WIDTH = 1
);
  localparam int EW = $clog2(AST_DWIDTH/8);

  logic [AST_DWIDTH-1:0]    data;
  logic                     valid;
  logic                     ready;
  logic                     startofpacket;
  logic                     endofpacket;
  logic [EW-1:0]            empty;
  logic [CHANNEL_WIDTH-1:0] channel;

  modport sink (
    input  data, valid, startofpacket, endofpacket, empty, channel,
    output ready
  );

  modport src (
    output data, valid, startofpacket, endofpacket, empty, channel,
    input  ready
  );
endinterface

// File: rtl/packet_filter.sv
// Store-and-forward packet filter: keeps or drops whole packets by channel mark.
// Define PACKET_FILTER_STATS_EN to build the saturating pass/drop counters.
module packet_filter #(
  parameter int AST_DWIDTH    = 64,
  parameter int CHANNEL_WIDTH = 1,
  parameter int BUF_DEPTH     = 256,
  parameter int DROP_MATCHED  = 0
) (
  input  logic        clk_i,
  input  logic        arst_n_i,
  avalon_st_if.sink   sink_if,
  avalon_st_if.src    src_if,
  output logic [31:0] pkt_pass_cnt_o,
  output logic [31:0] pkt_drop_cnt_o
);
  localparam int EW = $clog2(AST_DWIDTH/8);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int WW = AST_DWIDTH + EW + 1;
  localparam logic [AW:0] DEPTH = (AW+1)'(BUF_DEPTH);
  localparam logic [AW:0] ONE   = (AW+1)'(1);
  localparam logic        DM    = (DROP_MATCHED != 0);

  typedef enum logic [1:0] {IDLE, STORE, DISCARD} state_t;

  state_t                   state, state_d;
  logic [AW:0]              wr_ptr, wr_d;
  logic [AW:0]              commit_ptr, commit_d;
  logic [AW:0]              rd_ptr;
  logic [CHANNEL_WIDTH-1:0] mark, mark_d, mark_fin;
  logic                     full, ovf, rdy, acc, we, fin;
  logic [AW:0]              waddr;
  logic                     pass_inc;
  logic [1:0]               drop_inc;

  logic [WW-1:0] mem [BUF_DEPTH];
  logic [WW-1:0] rdata;
  logic          s1_v, out_ld, rd_en;
  logic          out_v, out_sop, out_eop, first;
  logic [AST_DWIDTH-1:0] out_d;
  logic [EW-1:0]         out_e;

  assign full  = (wr_ptr - rd_ptr) == DEPTH;
  assign ovf   = rd_ptr == commit_ptr;
  assign rdy   = (state != STORE) || !full || ovf;
  assign acc   = sink_if.valid && rdy;
  assign sink_if.ready = rdy;

  always_comb begin
    state_d  = state;
    wr_d     = wr_ptr;
    commit_d = commit_ptr;
    mark_d   = mark;
    we       = 1'b0;
    waddr    = wr_ptr;
    fin      = 1'b0;
    mark_fin = mark | sink_if.channel;
    pass_inc = 1'b0;
    drop_inc = 2'd0;
    unique case (state)
      IDLE: begin
        if (acc && sink_if.startofpacket) begin
          if (full) begin
            // committed data fills the buffer; this packet has no room
            drop_inc = 2'd1;
            if (!sink_if.endofpacket) state_d = DISCARD;
          end else begin
            we       = 1'b1;
            wr_d     = wr_ptr + ONE;
            mark_d   = sink_if.channel;
            mark_fin = sink_if.channel;
            fin      = sink_if.endofpacket;
            if (!sink_if.endofpacket) state_d = STORE;
          end
        end
      end
      STORE: begin
        if (acc && sink_if.startofpacket) begin
          drop_inc = 2'd1;
          we       = 1'b1;
          waddr    = commit_ptr;
          wr_d     = commit_ptr + ONE;
          mark_d   = sink_if.channel;
          mark_fin = sink_if.channel;
          fin      = sink_if.endofpacket;
          state_d  = sink_if.endofpacket ? IDLE : STORE;
        end else if (full && ovf) begin
          wr_d     = commit_ptr;
          mark_d   = '0;
          drop_inc = 2'd1;
          state_d  = (acc && sink_if.endofpacket) ? IDLE : DISCARD;
        end else if (acc) begin
          we     = 1'b1;
          wr_d   = wr_ptr + ONE;
          mark_d = mark_fin;
          fin    = sink_if.endofpacket;
          if (sink_if.endofpacket) state_d = IDLE;
        end
      end
      DISCARD: begin
        if (acc && sink_if.endofpacket) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (fin) begin
      mark_d = '0;
      if ((|mark_fin) ^ DM) begin
        commit_d = wr_d;
        pass_inc = 1'b1;
      end else begin
        wr_d     = commit_ptr;
        drop_inc = drop_inc + 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      mark       <= '0;
    end else begin
      state      <= state_d;
      wr_ptr     <= wr_d;
      commit_ptr <= commit_d;
      mark       <= mark_d;
    end
  end

  assign out_ld = s1_v && (!out_v || src_if.ready);
  assign rd_en  = (rd_ptr != commit_ptr) && (!s1_v || out_ld);

  always_ff @(posedge clk_i) begin
    if (we) mem[waddr[AW-1:0]] <= {sink_if.endofpacket, sink_if.empty, sink_if.data};
    if (rd_en) rdata <= mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      rd_ptr  <= '0;
      s1_v    <= 1'b0;
      out_v   <= 1'b0;
      out_sop <= 1'b0;
      out_eop <= 1'b0;
      out_d   <= '0;
      out_e   <= '0;
      first   <= 1'b1;
    end else begin
      if (rd_en) rd_ptr <= rd_ptr + ONE;
      if (rd_en) s1_v <= 1'b1;
      else if (out_ld) s1_v <= 1'b0;
      if (out_ld) begin
        out_v   <= 1'b1;
        out_d   <= rdata[AST_DWIDTH-1:0];
        out_e   <= rdata[AST_DWIDTH +: EW];
        out_eop <= rdata[WW-1];
        out_sop <= first;
        first   <= rdata[WW-1];
      end else if (src_if.ready) begin
        out_v <= 1'b0;
      end
    end
  end

  assign src_if.valid         = out_v;
  assign src_if.data          = out_d;
  assign src_if.empty         = out_e;
  assign src_if.startofpacket = out_sop;
  assign src_if.endofpacket   = out_eop;
  assign src_if.channel       = '0;

`ifdef PACKET_FILTER_STATS_EN
  logic [31:0] pass_cnt, drop_cnt;
  logic [32:0] pass_sum, drop_sum;

  assign pass_sum = {1'b0, pass_cnt} + 33'(pass_inc);
  assign drop_sum = {1'b0, drop_cnt} + 33'(drop_inc);

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      pass_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      pass_cnt <= pass_sum[32] ? '1 : pass_sum[31:0];
      drop_cnt <= drop_sum[32] ? '1 : drop_sum[31:0];
    end
  end

  assign pkt_pass_cnt_o = pass_cnt;
  assign pkt_drop_cnt_o = drop_cnt;
`else
  logic unused_stats;
  assign unused_stats   = ^{pass_inc, drop_inc};
  assign pkt_pass_cnt_o = '0;
  assign pkt_drop_cnt_o = '0;
`endif
endmodule
